id_hazard_scoreboard: RTL and testbench
=======================================

// Module: id_hazard_scoreboard
// PURPOSE
//  Parametrised forwarding/hazard unit for the decode stage; replaces fixed EX/MEM forwarding and one-cycle load-use stall.
//  Tracks up to PIPE_DEPTH in-flight writers in a shift-register scoreboard and selects the youngest ready producer per operand.
//  Raises stallreq while a matching producer is a load whose data is not yet available.
//  Sits between decoder and id_ex; stage_data comes from the EX/MEM/... result buses.
// PARAMETERS
//  XLEN       32  data width
//  RADDR_W    5   register address width
//  PIPE_DEPTH 3   tracked stages after ID (0=EX, 1=MEM, 2=WB-side); range 1..8
//  LOAD_LAT   1   cycles after entry into stage 0 before a load result can be forwarded; must satisfy LOAD_LAT < PIPE_DEPTH
// PORTS
//  clk          in  1                 clock
//  rst          in  1                 synchronous reset, active-high
//  flush        in  1                 branch/jump flush: drop all tracked entries
//  stall_in     in  1                 downstream stall from ctrl: freeze scoreboard
//  issue_valid  in  1                 decoded instruction leaves ID this cycle
//  issue_rd     in  RADDR_W           its destination
//  issue_rd_we  in  1                 it writes rd
//  issue_load   in  1                 it is a load (LB/LH/LW/LBU/LHU)
//  rs1_addr/rs2_addr in RADDR_W       source addresses
//  rs1_en/rs2_en     in 1             source read enables
//  rf_rs1_data/rf_rs2_data in XLEN    register-file read data (write-through)
//  stage_data   in  PIPE_DEPTH*XLEN   result of stage i at [i*XLEN +: XLEN]
//  rs1_val/rs2_val out XLEN           resolved operands
//  stallreq     out 1                 load-use hazard: hold IF/ID
// BEHAVIOUR
//  Entry i = {valid, rd[RADDR_W], cnt[$clog2(LOAD_LAT+1)]}; entry 0 is youngest.
//  Lookup (combinational, 0 latency): with rsX_en=0 -> rsX_val=0, no hazard; with addr==0 -> value 0.
//   Otherwise scan i=0..PIPE_DEPTH-1; first valid entry with rd==addr wins:
//   cnt==0 -> stage_data[i]; cnt!=0 -> hazard. No match -> rf_rsX_data.
//  stallreq = hazard(rs1) | hazard(rs2); rsX_val is don't-care while stallreq=1.
//  Update at posedge clk, priority: rst > flush > stall_in > shift.
//   rst: all valid=0, cnt=0. flush: all valid=0 (cnt cleared).
//   stall_in: all entries hold, counters do not decrement.
//   shift: entry[i]<=entry[i-1] with cnt decremented saturating at 0.
//    entry[0]<=bubble if stallreq or !issue_valid or !issue_rd_we or issue_rd==0.
//    Otherwise entry[0]<={1, issue_rd, issue_load ? LOAD_LAT : 0}.
//  Writers older than PIPE_DEPTH stages are covered by register-file write-through.
//  Same-rd producers in two stages: younger (lower i) wins, even when it stalls and the older one is ready.
//  While rst=1: rs1_val=rs2_val=0, stallreq=0.
//  After reset all outputs follow lookup on an empty scoreboard (rf data passthrough).
//  Flush and stallreq in the same cycle: flush wins; stallreq deasserts the next cycle.
// CONFIGURATION
//  ID_PERF_CNT_EN defined: adds ports
//   stall_cnt out 32: increments every cycle stallreq=1 and rst=0, wraps 0xFFFFFFFF->0, cleared by rst only.
//   fwd_cnt out 32: counts cycles with at least one operand forwarded, same wrap and reset rules.
//  ID_PERF_CNT_EN undefined: ports and counters absent; functional behaviour identical.
// TESTING
//  1 Reset -> rs1_en=1, rs1_addr=5, rf=0x11 -> rs1_val=0x11, stallreq=0.
//  2 Issue addi x5, then next cycle rs1_addr=5 with stage_data[0]=0xAB -> rs1_val=0xAB, no stall.
//  3 Load x6 (LOAD_LAT=1), dependent next cycle:
//    stallreq=1 for exactly 1 cycle; then stage_data[1]=0x1234 -> rs1_val=0x1234.
//  4 Issue x7 twice back-to-back (0x1 then 0x2 in stages 1/0) -> rs2_val=0x2 (youngest).
//  5 Load x8 then flush -> next cycle rs1_addr=8 -> stallreq=0, rs1_val=rf data.
//  6 Load x9 with stall_in=1 for 3 cycles -> stallreq stays 1 throughout, clears 1 cycle after stall_in drops.
//    With ID_PERF_CNT_EN, stall_cnt=4.

Source files
------------

// File: rtl/id_hazard_scoreboard_if.sv
// rtl/id_hazard_scoreboard_if.sv - decode-side issue/operand bundle for the hazard scoreboard
interface id_hazard_scoreboard_if #(
    parameter int XLEN       = 32,
    parameter int RADDR_W    = 5,
    parameter int PIPE_DEPTH = 3
);
  logic                       issue_valid;
  logic [RADDR_W-1:0]         issue_rd;
  logic                       issue_rd_we;
  logic                       issue_load;
  logic [RADDR_W-1:0]         rs1_addr;
  logic [RADDR_W-1:0]         rs2_addr;
  logic                       rs1_en;
  logic                       rs2_en;
  logic [XLEN-1:0]            rf_rs1_data;
  logic [XLEN-1:0]            rf_rs2_data;
  logic [PIPE_DEPTH*XLEN-1:0] stage_data;
  logic [XLEN-1:0]            rs1_val;
  logic [XLEN-1:0]            rs2_val;
  logic                       stallreq;

  modport master (
    output issue_valid, issue_rd, issue_rd_we, issue_load,
    output rs1_addr, rs2_addr, rs1_en, rs2_en,
    output rf_rs1_data, rf_rs2_data, stage_data,
    input  rs1_val, rs2_val, stallreq
  );

  modport slave (
    input  issue_valid, issue_rd, issue_rd_we, issue_load,
    input  rs1_addr, rs2_addr, rs1_en, rs2_en,
    input  rf_rs1_data, rf_rs2_data, stage_data,
    output rs1_val, rs2_val, stallreq
  );
endinterface

// File: rtl/id_hazard_scoreboard.sv
// rtl/id_hazard_scoreboard.sv - decode-stage forwarding/load-use scoreboard over PIPE_DEPTH stages
// Optional ID_PERF_CNT_EN adds stall_cnt/fwd_cnt performance counters.
module id_hazard_scoreboard #(
    parameter int XLEN       = 32,
    parameter int RADDR_W    = 5,
    parameter int PIPE_DEPTH = 3,
    parameter int LOAD_LAT   = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  stall_in,
    id_hazard_scoreboard_if.slave bus
`ifdef ID_PERF_CNT_EN
    ,
    output logic [31:0]           stall_cnt,
    output logic [31:0]           fwd_cnt
`endif
);

  localparam int CNT_W = (LOAD_LAT > 0) ? $clog2(LOAD_LAT + 1) : 1;
  localparam logic [CNT_W-1:0] LOAD_CNT = CNT_W'(LOAD_LAT);

  logic [PIPE_DEPTH-1:0] valid_q, valid_d;
  logic [RADDR_W-1:0]    rd_q  [PIPE_DEPTH];
  logic [RADDR_W-1:0]    rd_d  [PIPE_DEPTH];
  logic [CNT_W-1:0]      cnt_q [PIPE_DEPTH];
  logic [CNT_W-1:0]      cnt_d [PIPE_DEPTH];

  logic [RADDR_W-1:0] src_addr [2];
  logic               src_en   [2];
  logic [XLEN-1:0]    src_rf   [2];
  logic [XLEN-1:0]    src_val  [2];
  logic               src_haz  [2];
  logic               src_fwd  [2];
  logic               hazard;
  logic               take_issue;

  assign src_addr[0] = bus.rs1_addr;
  assign src_addr[1] = bus.rs2_addr;
  assign src_en[0]   = bus.rs1_en;
  assign src_en[1]   = bus.rs2_en;
  assign src_rf[0]   = bus.rf_rs1_data;
  assign src_rf[1]   = bus.rf_rs2_data;

  // Scan oldest to youngest so the youngest matching producer overrides.
  always_comb begin
    for (int s = 0; s < 2; s++) begin
      src_val[s] = src_rf[s];
      src_haz[s] = 1'b0;
      src_fwd[s] = 1'b0;
      for (int i = PIPE_DEPTH - 1; i >= 0; i--) begin
        if (valid_q[i] && rd_q[i] == src_addr[s]) begin
          if (cnt_q[i] == '0) begin
            src_val[s] = bus.stage_data[i*XLEN +: XLEN];
            src_haz[s] = 1'b0;
            src_fwd[s] = 1'b1;
          end else begin
            src_haz[s] = 1'b1;
            src_fwd[s] = 1'b0;
          end
        end
      end
      if (!src_en[s] || src_addr[s] == '0) begin
        src_val[s] = '0;
        src_haz[s] = 1'b0;
        src_fwd[s] = 1'b0;
      end
    end
  end

  assign hazard       = src_haz[0] | src_haz[1];
  assign bus.stallreq = !rst && hazard;
  assign bus.rs1_val  = rst ? '0 : src_val[0];
  assign bus.rs2_val  = rst ? '0 : src_val[1];

  assign take_issue = bus.issue_valid && bus.issue_rd_we && (bus.issue_rd != '0) && !hazard;

  always_comb begin
    valid_d = valid_q;
    rd_d    = rd_q;
    cnt_d   = cnt_q;
    if (flush) begin
      valid_d = '0;
      for (int i = 0; i < PIPE_DEPTH; i++) cnt_d[i] = '0;
    end else if (!stall_in) begin
      for (int i = PIPE_DEPTH - 1; i >= 1; i--) begin
        valid_d[i] = valid_q[i-1];
        rd_d[i]    = rd_q[i-1];
        cnt_d[i]   = (cnt_q[i-1] != '0) ? cnt_q[i-1] - CNT_W'(1) : '0;
      end
      valid_d[0] = take_issue;
      rd_d[0]    = take_issue ? bus.issue_rd : '0;
      cnt_d[0]   = (take_issue && bus.issue_load) ? LOAD_CNT : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      for (int i = 0; i < PIPE_DEPTH; i++) begin
        rd_q[i]  <= '0;
        cnt_q[i] <= '0;
      end
    end else begin
      valid_q <= valid_d;
      rd_q    <= rd_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef ID_PERF_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] fwd_cnt_q, fwd_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q + (hazard ? 32'd1 : 32'd0);
    fwd_cnt_d   = fwd_cnt_q + ((src_fwd[0] | src_fwd[1]) ? 32'd1 : 32'd0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
      fwd_cnt_q   <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      fwd_cnt_q   <= fwd_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign fwd_cnt   = fwd_cnt_q;
`endif

endmodule

// File: tb/tb_id_hazard_scoreboard.sv
// tb/tb_id_hazard_scoreboard.sv - directed bench with age-based writer model for id_hazard_scoreboard
module tb_id_hazard_scoreboard;
  localparam int XLEN = 32;
  localparam int RADDR_W = 5;
  localparam int PIPE_DEPTH = 3;
  localparam int LOAD_LAT = 1;

  logic clk = 1'b0;
  logic rst, flush, stall_in;
  always #5 clk = ~clk;

  id_hazard_scoreboard_if #(.XLEN(XLEN), .RADDR_W(RADDR_W), .PIPE_DEPTH(PIPE_DEPTH)) bus ();

`ifdef ID_PERF_CNT_EN
  logic [31:0] stall_cnt, fwd_cnt;
`endif

  id_hazard_scoreboard #(
      .XLEN(XLEN), .RADDR_W(RADDR_W), .PIPE_DEPTH(PIPE_DEPTH), .LOAD_LAT(LOAD_LAT)
  ) dut (
      .clk(clk), .rst(rst), .flush(flush), .stall_in(stall_in), .bus(bus)
`ifdef ID_PERF_CNT_EN
      , .stall_cnt(stall_cnt), .fwd_cnt(fwd_cnt)
`endif
  );

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Model: each tracked writer knows how many shifts it has seen; its stage is its age.
  typedef struct {
    logic [RADDR_W-1:0] rd;
    bit                 load;
    int                 age;
  } wr_t;
  wr_t mq[$];
  int unsigned m_stall_cnt = 0;
  int unsigned m_fwd_cnt = 0;

  function automatic void mlook(input logic en, input logic [RADDR_W-1:0] addr,
                                input logic [XLEN-1:0] rf, output logic [XLEN-1:0] val,
                                output bit haz, output bit fwd);
    logic [PIPE_DEPTH*XLEN-1:0] sd;
    sd = bus.stage_data;
    val = rf;
    haz = 0;
    fwd = 0;
    if (!en || addr == 0) begin
      val = 0;
      return;
    end
    foreach (mq[k]) begin
      if (mq[k].rd == addr) begin
        if (!mq[k].load || mq[k].age >= LOAD_LAT) begin
          val = sd[mq[k].age*XLEN +: XLEN];
          fwd = 1;
        end else begin
          haz = 1;
        end
        return;
      end
    end
  endfunction

  initial begin
    logic [XLEN-1:0] v1, v2;
    bit h1, h2, f1, f2, s;
    forever begin
      @(posedge clk);
      mlook(bus.rs1_en, bus.rs1_addr, bus.rf_rs1_data, v1, h1, f1);
      mlook(bus.rs2_en, bus.rs2_addr, bus.rf_rs2_data, v2, h2, f2);
      s = h1 | h2;
      if (rst) begin
        mq.delete();
        m_stall_cnt = 0;
        m_fwd_cnt = 0;
      end else begin
        if (s) m_stall_cnt++;
        if (f1 | f2) m_fwd_cnt++;
        if (flush) mq.delete();
        else if (!stall_in) begin
          foreach (mq[k]) mq[k].age++;
          while (mq.size() > 0 && mq[$].age >= PIPE_DEPTH) void'(mq.pop_back());
          if (!s && bus.issue_valid && bus.issue_rd_we && bus.issue_rd != 0)
            mq.push_front('{bus.issue_rd, bus.issue_load, 0});
        end
      end
    end
  end

  initial begin
    logic [XLEN-1:0] v1, v2;
    bit h1, h2, f1, f2;
    forever begin
      @(negedge clk);
      mlook(bus.rs1_en, bus.rs1_addr, bus.rf_rs1_data, v1, h1, f1);
      mlook(bus.rs2_en, bus.rs2_addr, bus.rf_rs2_data, v2, h2, f2);
      if (rst) begin
        chk("cyc_rst_stallreq", {31'd0, bus.stallreq}, 32'd0);
        chk("cyc_rst_rs1", bus.rs1_val, 32'd0);
        chk("cyc_rst_rs2", bus.rs2_val, 32'd0);
      end else begin
        chk("cyc_stallreq", {31'd0, bus.stallreq}, {31'd0, h1 | h2});
        if (!(h1 | h2)) begin
          chk("cyc_rs1", bus.rs1_val, v1);
          chk("cyc_rs2", bus.rs2_val, v2);
        end
`ifdef ID_PERF_CNT_EN
        chk("cyc_stall_cnt", stall_cnt, m_stall_cnt);
        chk("cyc_fwd_cnt", fwd_cnt, m_fwd_cnt);
`endif
      end
    end
  end

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #3;
  endtask

  task automatic set_sd(input logic [31:0] s0, input logic [31:0] s1, input logic [31:0] s2);
    bus.stage_data = {s2, s1, s0};
  endtask

  task automatic issue(input logic v, input logic [4:0] rd, input logic ld);
    bus.issue_valid = v;
    bus.issue_rd = rd;
    bus.issue_rd_we = v;
    bus.issue_load = ld;
  endtask

  initial begin
    rst = 1'b1;
    flush = 1'b0;
    stall_in = 1'b0;
    issue(1'b0, 5'd0, 1'b0);
    bus.rs1_en = 1'b1;
    bus.rs1_addr = 5'd5;
    bus.rs2_en = 1'b0;
    bus.rs2_addr = 5'd0;
    bus.rf_rs1_data = 32'h11;
    bus.rf_rs2_data = 32'h22;
    set_sd(32'h100, 32'h200, 32'h300);
    next();
    settle();
    chk("rst_rs1_zero", bus.rs1_val, 32'h0);
    chk("rst_stallreq", {31'd0, bus.stallreq}, 32'd0);
    next();
    rst = 1'b0;

    // 1: empty scoreboard passes register-file data through
    settle();
    chk("t1_rf_pass", bus.rs1_val, 32'h11);
    chk("t1_no_stall", {31'd0, bus.stallreq}, 32'd0);

    // 2: ALU producer forwarded from stage 0
    next();
    issue(1'b1, 5'd5, 1'b0);
    next();
    issue(1'b0, 5'd0, 1'b0);
    set_sd(32'hAB, 32'h200, 32'h300);
    settle();
    chk("t2_fwd_ex", bus.rs1_val, 32'hAB);
    chk("t2_no_stall", {31'd0, bus.stallreq}, 32'd0);
    repeat (3) next();
    settle();
    chk("t2_aged_out", bus.rs1_val, 32'h11);

    // 3: load-use stalls exactly one cycle, then forwards from stage 1
    issue(1'b1, 5'd6, 1'b1);
    next();
    issue(1'b1, 5'd10, 1'b0);
    bus.rs1_addr = 5'd6;
    settle();
    chk("t3_stall", {31'd0, bus.stallreq}, 32'd1);
    next();
    set_sd(32'h100, 32'h1234, 32'h300);
    settle();
    chk("t3_unstall", {31'd0, bus.stallreq}, 32'd0);
    chk("t3_fwd_mem", bus.rs1_val, 32'h1234);
    next();
    issue(1'b0, 5'd0, 1'b0);
    repeat (3) next();

    // 4: two writers of x7, youngest wins
    issue(1'b1, 5'd7, 1'b0);
    next();
    next();
    issue(1'b0, 5'd0, 1'b0);
    set_sd(32'h2, 32'h1, 32'h300);
    bus.rs2_en = 1'b1;
    bus.rs2_addr = 5'd7;
    settle();
    chk("t4_youngest", bus.rs2_val, 32'h2);
    repeat (3) next();

    // younger load stalls even though an older x7 is ready
    issue(1'b1, 5'd7, 1'b0);
    next();
    issue(1'b1, 5'd7, 1'b1);
    next();
    issue(1'b0, 5'd0, 1'b0);
    settle();
    chk("t4_young_load_stall", {31'd0, bus.stallreq}, 32'd1);
    next();
    set_sd(32'h100, 32'h77, 32'h66);
    settle();
    chk("t4_young_load_fwd", bus.rs2_val, 32'h77);
    bus.rs2_en = 1'b0;
    repeat (3) next();

    // 5: flush beats a pending load-use
    issue(1'b1, 5'd8, 1'b1);
    next();
    issue(1'b0, 5'd0, 1'b0);
    bus.rs1_addr = 5'd8;
    flush = 1'b1;
    settle();
    chk("t5_flush_cycle_stall", {31'd0, bus.stallreq}, 32'd1);
    next();
    flush = 1'b0;
    bus.rf_rs1_data = 32'h55;
    settle();
    chk("t5_after_flush_stall", {31'd0, bus.stallreq}, 32'd0);
    chk("t5_after_flush_rf", bus.rs1_val, 32'h55);

    // x0 and disabled reads resolve to zero
    issue(1'b1, 5'd0, 1'b1);
    next();
    issue(1'b0, 5'd0, 1'b0);
    bus.rs1_addr = 5'd0;
    bus.rs2_en = 1'b0;
    bus.rs2_addr = 5'd8;
    settle();
    chk("x0_zero", bus.rs1_val, 32'h0);
    chk("rs2_disabled_zero", bus.rs2_val, 32'h0);
    chk("x0_no_stall", {31'd0, bus.stallreq}, 32'd0);

    // 6: downstream stall freezes the load counter
    rst = 1'b1;
    next();
    rst = 1'b0;
    bus.rs1_addr = 5'd1;
    issue(1'b1, 5'd9, 1'b1);
    next();
    issue(1'b1, 5'd11, 1'b0);
    bus.rs1_addr = 5'd9;
    stall_in = 1'b1;
    for (int c = 0; c < 3; c++) begin
      settle();
      chk("t6_frozen_stall", {31'd0, bus.stallreq}, 32'd1);
      next();
    end
    stall_in = 1'b0;
    settle();
    chk("t6_release_stall", {31'd0, bus.stallreq}, 32'd1);
    next();
    set_sd(32'h100, 32'h9999, 32'h300);
    settle();
    chk("t6_cleared", {31'd0, bus.stallreq}, 32'd0);
    chk("t6_fwd", bus.rs1_val, 32'h9999);
`ifdef ID_PERF_CNT_EN
    chk("t6_stall_cnt", stall_cnt, 32'd4);
`endif
    next();
    issue(1'b0, 5'd0, 1'b0);
    repeat (4) next();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
